// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART frame sender
//
// Purpose: FSM state enums, frame length, byte index constants, default
//          SYNC value and the frame byte selector used by uart_frame_sender.
// Ports:   none (package).

package uart_pkg;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
   localparam int         FRAME_LEN         = 5;

   localparam logic [2:0] IDX_SYNC    = 3'd0;
   localparam logic [2:0] IDX_SEQ     = 3'd1;
   localparam logic [2:0] IDX_DATA_HI = 3'd2;
   localparam logic [2:0] IDX_DATA_LO = 3'd3;
   localparam logic [2:0] IDX_CSUM    = 3'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_LATCH,
      ST_SEND,
      ST_NEXT
   } state_t;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_LOAD,
      HS_WAIT_ACK,
      HS_WAIT_DONE
   } hs_state_t;

   function automatic logic [7:0] frame_byte(
      input logic [2:0]  idx,
      input logic [7:0]  sync,
      input logic [7:0]  seq,
      input logic [15:0] word,
      input logic [7:0]  csum
   );
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         IDX_SYNC:    b = sync;
         IDX_SEQ:     b = seq;
         IDX_DATA_HI: b = word[15:8];
         IDX_DATA_LO: b = word[7:0];
         IDX_CSUM:    b = csum;
         default:     b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/tx_byte_hs.sv
// rtl/tx_byte_hs.sv - single-byte transmit handshake with ack timeout
//
// Purpose: on start, waits for the transmitter to be free, strobes one byte,
//          then waits for tx_busy to rise (bounded by ACK_TIMEOUT) and fall.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        request to send byte_in (accepted only when idle)
//   byte_in      byte to send, sampled when the strobe is issued
//   tx_busy      transmitter busy flag
//   done         one-cycle pulse: byte finished (or abandoned on timeout)
//   timeout      one-cycle pulse together with done when no ack was seen
//   tx_data      registered byte to the transmitter, held between strobes
//   tx_wr_en     registered one-cycle transmit strobe

module tx_byte_hs
   import uart_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] byte_in,
   input  logic       tx_busy,
   output logic       done,
   output logic       timeout,
   output logic [7:0] tx_data,
   output logic       tx_wr_en
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   hs_state_t     state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [7:0]    tx_data_nx;
   logic          tx_wr_en_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= HS_IDLE;
         cnt      <= '0;
         tx_data  <= 8'h00;
         tx_wr_en <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         tx_data  <= tx_data_nx;
         tx_wr_en <= tx_wr_en_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      tx_data_nx  = tx_data;
      tx_wr_en_nx = 1'b0;
      done        = 1'b0;
      timeout     = 1'b0;
      case (state)
         HS_IDLE: begin
            if (start) state_nx = HS_LOAD;
         end
         HS_LOAD: begin
            if (!tx_busy) begin
               tx_data_nx  = byte_in;
               tx_wr_en_nx = 1'b1;
               cnt_nx      = '0;
               state_nx    = HS_WAIT_ACK;
            end
         end
         HS_WAIT_ACK: begin
            // The strobe is visible during the first WAIT_ACK cycle, so that
            // cycle counts as the first of the ACK_TIMEOUT waiting cycles.
            if (tx_busy) begin
               state_nx = HS_WAIT_DONE;
            end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
               timeout  = 1'b1;
               done     = 1'b1;
               state_nx = HS_IDLE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         HS_WAIT_DONE: begin
            if (!tx_busy) begin
               done     = 1'b1;
               state_nx = HS_IDLE;
            end
         end
         default: state_nx = HS_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_frame_sender.sv
// rtl/uart_frame_sender.sv - wraps FIFO words into 5-byte UART frames
//
// Purpose: pops one 16-bit word per frame and sends SYNC, SEQ, DATA_HI,
//          DATA_LO, CSUM through the transmitter wr_en/busy handshake.
// Ports:
//   clk_50m, rst_n        clock (also FIFO read clock), async active-low reset
//   enable                allow new frames; a frame in flight always completes
//   fifo_empty, fifo_q    FIFO read side; q valid one cycle after fifo_rdreq
//   fifo_rdreq            one-cycle pop strobe
//   tx_busy               transmitter busy flag
//   tx_data, tx_wr_en     byte and one-cycle strobe to the transmitter
//   frame_cnt             completed frames, wrapping
//   busy                  high whenever the FSM is not idle
//   ack_err               sticky: the transmitter failed to acknowledge a byte

module uart_frame_sender
   import uart_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
   parameter int unsigned ACK_TIMEOUT = 64,
   parameter logic [7:0]  SEQ_INIT    = 8'h00
) (
   input  logic        clk_50m,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        fifo_empty,
   input  logic [15:0] fifo_q,
   output logic        fifo_rdreq,
   input  logic        tx_busy,
   output logic [7:0]  tx_data,
   output logic        tx_wr_en,
   output logic [15:0] frame_cnt,
   output logic        busy,
   output logic        ack_err
);

   state_t      state, state_nx;
   logic [2:0]  idx, idx_nx;
   logic [7:0]  seq, seq_nx;
   logic [15:0] word_r, word_nx;
   logic [7:0]  csum_r, csum_nx;
   logic [15:0] frame_cnt_nx;
   logic        rdreq_nx, busy_nx, ack_err_nx;

   logic        hs_start, hs_done, hs_timeout;
   logic [7:0]  hs_byte;

   // The handshake is kicked off from POP so that SYNC (which does not depend
   // on the popped word) goes out while LATCH captures the data; this keeps
   // the gap between frames down to three cycles.
   assign hs_start = (state == ST_POP) || ((state == ST_NEXT) && (idx != IDX_CSUM));
   assign hs_byte  = frame_byte(idx, SYNC_BYTE, seq, word_r, csum_r);

   tx_byte_hs #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_hs (
      .clk     (clk_50m),
      .rst_n   (rst_n),
      .start   (hs_start),
      .byte_in (hs_byte),
      .tx_busy (tx_busy),
      .done    (hs_done),
      .timeout (hs_timeout),
      .tx_data (tx_data),
      .tx_wr_en(tx_wr_en)
   );

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         idx        <= IDX_SYNC;
         seq        <= SEQ_INIT;
         word_r     <= 16'h0000;
         csum_r     <= 8'h00;
         frame_cnt  <= 16'h0000;
         fifo_rdreq <= 1'b0;
         busy       <= 1'b0;
         ack_err    <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         seq        <= seq_nx;
         word_r     <= word_nx;
         csum_r     <= csum_nx;
         frame_cnt  <= frame_cnt_nx;
         fifo_rdreq <= rdreq_nx;
         busy       <= busy_nx;
         ack_err    <= ack_err_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      seq_nx       = seq;
      word_nx      = word_r;
      csum_nx      = csum_r;
      frame_cnt_nx = frame_cnt;
      rdreq_nx     = 1'b0;
      ack_err_nx   = ack_err;
      case (state)
         ST_IDLE: begin
            if (enable && !fifo_empty) begin
               rdreq_nx = 1'b1;
               state_nx = ST_POP;
            end
         end
         ST_POP: begin
            state_nx = ST_LATCH;
         end
         ST_LATCH: begin
            word_nx  = fifo_q;
            csum_nx  = seq + fifo_q[15:8] + fifo_q[7:0];
            idx_nx   = IDX_SYNC;
            state_nx = ST_SEND;
         end
         ST_SEND: begin
            if (hs_timeout) ack_err_nx = 1'b1;
            if (hs_done)    state_nx   = ST_NEXT;
         end
         ST_NEXT: begin
            if (idx != IDX_CSUM) begin
               idx_nx   = idx + 3'd1;
               state_nx = ST_SEND;
            end else begin
               frame_cnt_nx = frame_cnt + 16'd1;
               seq_nx       = seq + 8'd1;
               // idx must already be SYNC when the next POP starts the handshake.
               idx_nx       = IDX_SYNC;
               if (enable && !fifo_empty) begin
                  rdreq_nx = 1'b1;
                  state_nx = ST_POP;
               end else begin
                  state_nx = ST_IDLE;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      busy_nx = (state_nx != ST_IDLE);
   end

endmodule

// File: tb/tb_uart_frame_sender.sv
// tb/tb_uart_frame_sender.sv - directed self-checking bench for uart_frame_sender

module tb_uart_frame_sender;

   logic        clk_50m = 1'b0;
   logic        rst_n   = 1'b0;
   logic        enable  = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [15:0] fifo_q  = 16'h0000;
   logic        fifo_rdreq;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_wr_en;
   logic [15:0] frame_cnt;
   logic        busy;
   logic        ack_err;

   int checks = 0;
   int errors = 0;

   logic [15:0] fifo_mem[$];
   logic [7:0]  tx_log[$];
   int          strobe_cyc[$];
   int          cyc = 0;
   int          rdreq_cnt = 0;
   int          rd_empty_viol = 0;
   int          last_fall = -1;
   int          max_gap = 0;
   logic        prev_busy = 1'b0;
   logic        never_busy = 1'b0;
   int          tx_cnt = 0;

   uart_frame_sender dut (
      .clk_50m   (clk_50m),
      .rst_n     (rst_n),
      .enable    (enable),
      .fifo_empty(fifo_empty),
      .fifo_q    (fifo_q),
      .fifo_rdreq(fifo_rdreq),
      .tx_busy   (tx_busy),
      .tx_data   (tx_data),
      .tx_wr_en  (tx_wr_en),
      .frame_cnt (frame_cnt),
      .busy      (busy),
      .ack_err   (ack_err)
   );

   always #5 clk_50m = ~clk_50m;

   // Transmitter model: busy for 10 cycles starting the cycle after a strobe.
   always @(posedge clk_50m) begin
      if (tx_wr_en)        tx_cnt <= 10;
      else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
   end
   assign tx_busy = (tx_cnt != 0) && !never_busy;

   // Monitor and FIFO read-side model, evaluated away from the active edge.
   always @(negedge clk_50m) begin
      cyc = cyc + 1;
      if (prev_busy && !tx_busy) last_fall = cyc;
      prev_busy = tx_busy;
      if (tx_wr_en) begin
         if (tx_log.size() > 0 && (tx_log.size() % 5) == 0 && last_fall >= 0)
            if (cyc - last_fall - 1 > max_gap) max_gap = cyc - last_fall - 1;
         tx_log.push_back(tx_data);
         strobe_cyc.push_back(cyc);
      end
      if (fifo_rdreq) begin
         rdreq_cnt = rdreq_cnt + 1;
         if (fifo_empty) rd_empty_viol = rd_empty_viol + 1;
         else fifo_q = fifo_mem.pop_front();
         fifo_empty = (fifo_mem.size() == 0);
      end
   end

   task automatic push_word(input logic [15:0] w);
      fifo_mem.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_50m);
      enable = 1'b0;
      never_busy = 1'b0;
      rst_n = 1'b0;
      fifo_mem.delete();
      fifo_empty = 1'b1;
      repeat (3) @(negedge clk_50m);
      tx_log.delete();
      strobe_cyc.delete();
      rdreq_cnt = 0;
      rd_empty_viol = 0;
      last_fall = -1;
      max_gap = 0;
      rst_n = 1'b1;
      @(negedge clk_50m);
   endtask

   task automatic wait_idle(input int max_cyc, output bit ok);
      ok = 1'b0;
      repeat (4) @(negedge clk_50m);
      for (int i = 0; i < max_cyc; i++) begin
         if (!busy && !tx_busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk_50m);
      end
   endtask

   task automatic wait_strobes(input int n, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk_50m);
         if (tx_log.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got %0b want 0", fifo_rdreq); end
      checks++; if (tx_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %0b want 0", tx_wr_en); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
      checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL reset_frame_cnt got %h want 0000", frame_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %0b want 0", ack_err); end
   endtask

   task automatic test_single_frame();
      logic [7:0] exp [0:4];
      bit ok;
      exp = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h46};
      do_reset();
      push_word(16'h1234);
      enable = 1'b1;
      wait_idle(500, ok);
      checks++; if (!ok) begin errors++; $display("FAIL single_idle got busy want idle within bound"); end
      checks++; if (tx_log.size() != 5) begin errors++; $display("FAIL single_len got %0d want 5", tx_log.size()); end
      for (int i = 0; i < 5 && i < tx_log.size(); i++) begin
         checks++; if (tx_log[i] !== exp[i]) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, tx_log[i], exp[i]); end
      end
      checks++; if (rdreq_cnt != 1) begin errors++; $display("FAIL single_rdreq got %0d want 1", rdreq_cnt); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %0b want 0", busy); end
      checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL single_ack_err got %0b want 0", ack_err); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [0:14];
      bit ok;
      exp = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'hFE,
              8'hA5, 8'h01, 8'h00, 8'h01, 8'h02,
              8'hA5, 8'h02, 8'h80, 8'h00, 8'h82};
      do_reset();
      push_word(16'hFFFF);
      push_word(16'h0001);
      push_word(16'h8000);
      enable = 1'b1;
      wait_idle(1500, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_idle got busy want idle within bound"); end
      checks++; if (tx_log.size() != 15) begin errors++; $display("FAIL b2b_len got %0d want 15", tx_log.size()); end
      for (int i = 0; i < 15 && i < tx_log.size(); i++) begin
         checks++; if (tx_log[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, tx_log[i], exp[i]); end
      end
      checks++; if (rdreq_cnt != 3) begin errors++; $display("FAIL b2b_rdreq got %0d want 3", rdreq_cnt); end
      checks++; if (rd_empty_viol != 0) begin errors++; $display("FAIL b2b_rd_empty got %0d want 0", rd_empty_viol); end
      checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_frame_cnt got %0d want 3", frame_cnt); end
      checks++; if (max_gap > 3) begin errors++; $display("FAIL b2b_gap got %0d want <=3", max_gap); end
   endtask

   task automatic test_timeout();
      logic [7:0] exp [0:4];
      bit ok;
      exp = '{8'hA5, 8'h00, 8'h56, 8'h78, 8'hCE};
      do_reset();
      never_busy = 1'b1;
      push_word(16'h5678);
      enable = 1'b1;
      wait_idle(1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL tmo_idle got busy want idle within bound"); end
      checks++; if (tx_log.size() != 5) begin errors++; $display("FAIL tmo_len got %0d want 5", tx_log.size()); end
      for (int i = 0; i < 5 && i < tx_log.size(); i++) begin
         checks++; if (tx_log[i] !== exp[i]) begin errors++; $display("FAIL tmo_byte%0d got %h want %h", i, tx_log[i], exp[i]); end
      end
      if (strobe_cyc.size() >= 2) begin
         checks++; if (strobe_cyc[1] - strobe_cyc[0] != 66) begin errors++; $display("FAIL tmo_spacing got %0d want 66", strobe_cyc[1] - strobe_cyc[0]); end
      end
      checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL tmo_ack_err got %0b want 1", ack_err); end
      never_busy = 1'b0;
      repeat (20) @(negedge clk_50m);
      checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL tmo_ack_sticky got %0b want 1", ack_err); end
   endtask

   task automatic test_enable_drop();
      bit ok;
      do_reset();
      push_word(16'hAAAA);
      push_word(16'h5555);
      enable = 1'b1;
      wait_strobes(2, 200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL drop_strobes got %0d want 2 within bound", tx_log.size()); end
      enable = 1'b0;
      wait_idle(500, ok);
      repeat (20) @(negedge clk_50m);
      checks++; if (!ok) begin errors++; $display("FAIL drop_idle got busy want idle within bound"); end
      checks++; if (tx_log.size() != 5) begin errors++; $display("FAIL drop_len got %0d want 5", tx_log.size()); end
      if (tx_log.size() >= 5) begin
         checks++; if (tx_log[4] !== 8'h54) begin errors++; $display("FAIL drop_csum got %h want 54", tx_log[4]); end
      end
      checks++; if (rdreq_cnt != 1) begin errors++; $display("FAIL drop_rdreq got %0d want 1", rdreq_cnt); end
      checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL drop_fifo got empty=%0b want 0", fifo_empty); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %0b want 0", busy); end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL drop_frame_cnt got %0d want 1", frame_cnt); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] exp [0:4];
      bit ok;
      int n;
      exp = '{8'hA5, 8'h00, 8'h9A, 8'hBC, 8'h56};
      do_reset();
      push_word(16'h1234);
      push_word(16'h9ABC);
      enable = 1'b1;
      wait_strobes(3, 200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_strobes got %0d want 3 within bound", tx_log.size()); end
      n = 0;
      while (!tx_busy && n < 20) begin
         @(negedge clk_50m);
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
      checks++; if (tx_wr_en !== 1'b0) begin errors++; $display("FAIL rstmid_wr_en got %0b want 0", tx_wr_en); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx_data got %h want 00", tx_data); end
      checks++; if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL rstmid_rdreq got %0b want 0", fifo_rdreq); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_frame_cnt got %0d want 0", frame_cnt); end
      repeat (2) @(negedge clk_50m);
      tx_log.delete();
      rst_n = 1'b1;
      wait_idle(500, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_idle got busy want idle within bound"); end
      checks++; if (tx_log.size() != 5) begin errors++; $display("FAIL rstmid_len got %0d want 5", tx_log.size()); end
      for (int i = 0; i < 5 && i < tx_log.size(); i++) begin
         checks++; if (tx_log[i] !== exp[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h want %h", i, tx_log[i], exp[i]); end
      end
      checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_frame_cnt_after got %0d want 1", frame_cnt); end
   endtask

   task automatic test_seq_wrap();
      bit ok;
      do_reset();
      for (int i = 0; i < 257; i++) push_word(16'h0000);
      enable = 1'b1;
      wait_idle(30000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_idle got busy want idle within bound"); end
      checks++; if (tx_log.size() != 1285) begin errors++; $display("FAIL wrap_len got %0d want 1285", tx_log.size()); end
      if (tx_log.size() == 1285) begin
         checks++; if (tx_log[1276] !== 8'hFF) begin errors++; $display("FAIL wrap_seq255 got %h want ff", tx_log[1276]); end
         checks++; if (tx_log[1279] !== 8'hFF) begin errors++; $display("FAIL wrap_csum255 got %h want ff", tx_log[1279]); end
         checks++; if (tx_log[1280] !== 8'hA5) begin errors++; $display("FAIL wrap_sync256 got %h want a5", tx_log[1280]); end
         checks++; if (tx_log[1281] !== 8'h00) begin errors++; $display("FAIL wrap_seq256 got %h want 00", tx_log[1281]); end
      end
      checks++; if (frame_cnt !== 16'd257) begin errors++; $display("FAIL wrap_frame_cnt got %0d want 257", frame_cnt); end
      checks++; if (rdreq_cnt != 257) begin errors++; $display("FAIL wrap_rdreq got %0d want 257", rdreq_cnt); end
      checks++; if (rd_empty_viol != 0) begin errors++; $display("FAIL wrap_rd_empty got %0d want 0", rd_empty_viol); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_timeout();
      test_enable_drop();
      test_reset_mid_frame();
      test_seq_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
